// File: rtl/sha_msg_padder.sv
// rtl/sha_msg_padder.sv - SHA-256 message padder feeding 512-bit blocks to the hash core
module sha_msg_padder (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         in_ready,
    output logic [511:0] msg_block,
    output logic         first_block,
    output logic         begin_computation,
    output logic         enable_computation,
    input  logic         computation_complete,
    output logic         msg_done
);

    typedef enum logic [1:0] {
        S_FILL,
        S_SEND,
        S_WAIT,
        S_LEN
    } state_t;

    state_t       state_q, state_d;
    logic [31:0]  buf_q [16];
    logic [31:0]  buf_d [16];
    logic [3:0]   word_idx_q, word_idx_d;
    logic [63:0]  bitlen_q, bitlen_d;
    logic         len_pending_q, len_pending_d;
    // 0x80 spilled past word 15 (message ends exactly on a block boundary)
    logic         pad_pending_q, pad_pending_d;
    logic         final_q, final_d;
    logic         first_q, first_d;
    logic         msg_done_q, msg_done_d;

    logic [2:0]   nb;
    logic [4:0]   pad_idx;
    logic [4:0]   next_idx;
    logic [31:0]  keep_mask;

    // State, buffer and counters; reset aborts any block in flight
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_FILL;
            for (int i = 0; i < 16; i++) buf_q[i] <= 32'd0;
            word_idx_q    <= 4'd0;
            bitlen_q      <= 64'd0;
            len_pending_q <= 1'b0;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
            first_q       <= 1'b1;
            msg_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            for (int i = 0; i < 16; i++) buf_q[i] <= buf_d[i];
            word_idx_q    <= word_idx_d;
            bitlen_q      <= bitlen_d;
            len_pending_q <= len_pending_d;
            pad_pending_q <= pad_pending_d;
            final_q       <= final_d;
            first_q       <= first_d;
            msg_done_q    <= msg_done_d;
        end
    end

    // Next-state logic: word capture, padding placement and block handshake
    always_comb begin
        state_d       = state_q;
        for (int i = 0; i < 16; i++) buf_d[i] = buf_q[i];
        word_idx_d    = word_idx_q;
        bitlen_d      = bitlen_q;
        len_pending_d = len_pending_q;
        pad_pending_d = pad_pending_q;
        final_d       = final_q;
        first_d       = first_q;
        msg_done_d    = 1'b0;
        nb            = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
        pad_idx       = {1'b0, word_idx_q};
        next_idx      = pad_idx + 5'd1;
        keep_mask     = ~(32'hFFFF_FFFF >> {nb[1:0], 3'b000});

        case (state_q)
            S_FILL: begin
                if (in_valid && !in_last) begin
                    buf_d[word_idx_q] = in_data;
                    bitlen_d          = bitlen_q + 64'd32;
                    word_idx_d        = word_idx_q + 4'd1;
                    if (word_idx_q == 4'd15) begin
                        final_d = 1'b0;
                        state_d = S_SEND;
                    end
                end else if (in_valid) begin
                    bitlen_d = bitlen_q + {58'd0, nb, 3'b000};
                    if (nb == 3'd4) begin
                        buf_d[word_idx_q] = in_data;
                        pad_idx           = {1'b0, word_idx_q} + 5'd1;
                        if (!pad_idx[4]) buf_d[pad_idx[3:0]] = 32'h8000_0000;
                        else             pad_pending_d       = 1'b1;
                    end else begin
                        buf_d[word_idx_q] = (in_data & keep_mask)
                                          | (32'h8000_0000 >> {nb[1:0], 3'b000});
                    end
                    next_idx = pad_idx + 5'd1;
                    if (next_idx <= 5'd14) begin
                        buf_d[14] = bitlen_d[63:32];
                        buf_d[15] = bitlen_d[31:0];
                        final_d   = 1'b1;
                    end else begin
                        len_pending_d = 1'b1;
                        final_d       = 1'b0;
                    end
                    state_d = S_SEND;
                end
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (computation_complete) begin
                    for (int i = 0; i < 16; i++) buf_d[i] = 32'd0;
                    word_idx_d = 4'd0;
                    first_d    = 1'b0;
                    if (final_q) begin
                        msg_done_d = 1'b1;
                        bitlen_d   = 64'd0;
                        first_d    = 1'b1;
                        state_d    = S_FILL;
                    end else if (len_pending_q) begin
                        len_pending_d = 1'b0;
                        pad_pending_d = 1'b0;
                        if (pad_pending_q) buf_d[0] = 32'h8000_0000;
                        buf_d[14] = bitlen_q[63:32];
                        buf_d[15] = bitlen_q[31:0];
                        state_d   = S_LEN;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_LEN: begin
                final_d = 1'b1;
                state_d = S_SEND;
            end
            default: state_d = S_FILL;
        endcase
    end

    // Output decode; in_ready is held low while reset is asserted
    always_comb begin
        for (int i = 0; i < 16; i++) msg_block[511 - 32*i -: 32] = buf_q[i];
        in_ready           = (state_q == S_FILL) && n_rst;
        begin_computation  = (state_q == S_SEND);
        enable_computation = (state_q == S_SEND) || (state_q == S_WAIT);
        first_block        = first_q;
        msg_done           = msg_done_q;
    end

endmodule

// File: tb/tb_sha_msg_padder.sv
// tb/tb_sha_msg_padder.sv - self-checking bench for sha_msg_padder
module tb_sha_msg_padder;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [31:0]  in_data = 32'd0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = 3'd0;
    logic         in_ready;
    logic [511:0] msg_block;
    logic         first_block;
    logic         begin_computation;
    logic         enable_computation;
    logic         computation_complete = 1'b0;
    logic         msg_done;

    sha_msg_padder dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_last              (in_last),
        .in_nbytes            (in_nbytes),
        .in_ready             (in_ready),
        .msg_block            (msg_block),
        .first_block          (first_block),
        .begin_computation    (begin_computation),
        .enable_computation   (enable_computation),
        .computation_complete (computation_complete),
        .msg_done             (msg_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_q[$];
    logic [511:0] got_q[$];
    logic         got_first[$];
    int           acc_cyc;
    int           begin_cyc0;

    typedef struct {
        int len;
        int delay;
        int exp_blocks;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] blk, input int j);
        return blk[511 - 32*j -: 32];
    endfunction

    // Reference: standard SHA-256 padding computed on a byte list
    function automatic void build_expected();
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] b;
        p = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_q.delete();
        for (int k = 0; k < p.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = p[64*k + j];
            exp_q.push_back(b);
        end
    endfunction

    task automatic drive_msg();
        int n = msg_q.size();
        int nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            int nb = (w == nw - 1) ? n - 4*w : 4;
            int t = 0;
            logic [31:0] d;
            for (int b = 0; b < 4; b++)
                d[31 - 8*b -: 8] = (b < nb) ? msg_q[4*w + b] : 8'($urandom);
            in_data   = d;
            in_valid  = 1'b1;
            in_last   = (w == nw - 1);
            in_nbytes = 3'(nb);
            while (!in_ready && t < 2000) begin @(negedge clk); t++; end
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (w == nw - 1) acc_cyc = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic respond(input int delay);
        int nblk = exp_q.size();
        for (int k = 0; k < nblk; k++) begin
            int t = 0;
            logic [511:0] blk;
            while (!begin_computation && t < 2000) begin @(negedge clk); t++; end
            if (!begin_computation) begin
                chk("begin_timeout", 0, 1);
                return;
            end
            if (k == 0) begin_cyc0 = cyc;
            blk = msg_block;
            got_q.push_back(blk);
            got_first.push_back(first_block);
            chk("block_data", blk, exp_q[k]);
            chk("first_block", first_block, (k == 0));
            chk("enable_at_begin", enable_computation, 1);
            for (int i = 0; i <= delay; i++) begin
                @(negedge clk);
                chk("hold_block", msg_block, blk);
                chk("hold_ctl", {enable_computation, begin_computation, in_ready}, 3'b100);
            end
            computation_complete = 1'b1;
            @(negedge clk);
            computation_complete = 1'b0;
            chk("enable_drop", enable_computation, 0);
            chk("msg_done", msg_done, (k == nblk - 1));
            if (k == nblk - 1) begin
                @(negedge clk);
                chk("msg_done_pulse", msg_done, 0);
                chk("ready_after", in_ready, 1);
            end
        end
    endtask

    task automatic run_msg(input int delay);
        build_expected();
        got_q.delete();
        got_first.delete();
        @(negedge clk);
        fork
            drive_msg();
            respond(delay);
        join
    endtask

    task automatic rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0,   0, 1};
        vecs[1]  = '{3,   1, 1};
        vecs[2]  = '{55,  2, 1};
        vecs[3]  = '{56,  0, 2};
        vecs[4]  = '{60,  1, 2};
        vecs[5]  = '{63,  0, 2};
        vecs[6]  = '{64,  3, 2};
        vecs[7]  = '{80,  2, 2};
        vecs[8]  = '{119, 0, 2};
        vecs[9]  = '{120, 1, 3};
        vecs[10] = '{128, 0, 3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_msg_block", msg_block, 0);
        chk("rst_ctl", {begin_computation, enable_computation, msg_done}, 3'b000);
        chk("rst_first", first_block, 1);
        n_rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        // Empty message
        msg_q.delete();
        run_msg(0);
        chk("empty_block", got_q[0], {32'h8000_0000, 480'd0});
        chk("empty_latency", begin_cyc0, acc_cyc + 1);

        // "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg(2);
        chk("abc_block", got_q[0], {32'h6162_6380, 448'd0, 32'h0000_0018});
        chk("abc_latency", begin_cyc0, acc_cyc + 1);

        // 55 bytes: single block, length right behind the pad
        rand_msg(55);
        run_msg(0);
        chk("b55_w13_pad", word_of(got_q[0], 13) & 32'hFF, 32'h80);
        chk("b55_len", {word_of(got_q[0], 14), word_of(got_q[0], 15)}, 64'h1B8);

        // 56 bytes: length spills into a second block
        rand_msg(56);
        run_msg(1);
        chk("b56_nblk", got_q.size(), 2);
        chk("b56_b0_pad", {word_of(got_q[0], 14), word_of(got_q[0], 15)}, 64'h8000_0000_0000_0000);
        chk("b56_b1", got_q[1], 512'h1C0);
        chk("b56_first", {got_first[0], got_first[1]}, 2'b10);

        // 80-byte header with slow core
        rand_msg(80);
        run_msg(50);
        chk("b80_w4", word_of(got_q[1], 4), 32'h8000_0000);
        chk("b80_w15", word_of(got_q[1], 15), 32'h0000_0280);

        // Table of lengths around block boundaries
        for (int v = 0; v < 11; v++) begin
            rand_msg(vecs[v].len);
            run_msg(vecs[v].delay);
            chk($sformatf("tbl_nblk_len%0d", vecs[v].len), got_q.size(), vecs[v].exp_blocks);
        end

        // Random lengths against the reference
        for (int r = 0; r < 12; r++) begin
            rand_msg($urandom_range(0, 200));
            run_msg($urandom_range(0, 5));
        end

        // Reset while a block sits in the core
        msg_q = '{8'h61, 8'h62, 8'h63};
        @(negedge clk);
        drive_msg();
        repeat (3) @(negedge clk);
        chk("pre_rst_enable", enable_computation, 1);
        n_rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_block", msg_block, 0);
        chk("midrst_ctl", {begin_computation, enable_computation, msg_done}, 3'b000);
        chk("midrst_first", first_block, 1);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("postrst_done", msg_done, 0);
        run_msg(0);
        chk("postrst_abc", got_q[0], {32'h6162_6380, 448'd0, 32'h0000_0018});
        chk("postrst_first", got_first[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
- Upstream feeder for the SHA-256 computational block.
- Accepts a byte-aligned message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit bit-length.
- Emits one or more 512-bit blocks, handshaking each block with the SHA block's begin/enable/complete signals.
- Typical payload is the 80-byte bitcoin header, which produces 2 blocks.

Parameters:
- none (block size 512, word size 32 and length field 64 are fixed by SHA-256).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- in_data  input  32  message word; first byte in [31:24]
- in_valid  input  1  in_data valid
- in_last  input  1  final word of message
- in_nbytes  input  3  valid bytes in the final word (0..4, left-justified); ignored unless in_last. Non-final words are always 4 bytes.
- in_ready  output  1  word accepted when in_valid && in_ready
- msg_block  output  512  current block; word 0 in [511:480]
- first_block  output  1  msg_block is block 0 of the message (SHA core initialises from H0)
- begin_computation  output  1  one-cycle start pulse to SHA block
- enable_computation  output  1  held high while a block is in the SHA block
- computation_complete  input  1  SHA block finished current block
- msg_done  output  1  one-cycle pulse when the final block completes

Behaviour:
- Reset (async, n_rst=0): all outputs 0, buffer zero, word_idx=0, bitlen=0, first_block=1, state FILL.
- Internal state: 16x32 buffer; word_idx[3:0]; bitlen[63:0] (wraps mod 2^64); len_pending flag.
- States: FILL, SEND, WAIT, LEN.
- FILL:
  - in_ready=1.
  - Non-last accept: buffer[word_idx]=in_data; bitlen+=32; word_idx++. If word_idx was 15 -> SEND (non-final).
  - Last accept: store the in_nbytes bytes. Place 0x80 in the next byte: same word if in_nbytes<4, else word_idx+1. bitlen+=8*in_nbytes. Let next = index after the 0x80 word.
    - next<=14: write bitlen (post-add) into words 14,15 -> SEND (final).
    - next>=15: set len_pending -> SEND (non-final).
  - in_nbytes=0 with in_last: 0x80 goes at byte 0 of word_idx, using the same rules.
- SEND:
  - One cycle; begin_computation=1, enable_computation=1, in_ready=0.
  - msg_block is stable from SEND until leaving WAIT.
  - Next state: WAIT.
- WAIT:
  - enable_computation=1; in_ready=0.
  - Stay until computation_complete=1. On that cycle:
    - clear buffer to zero; word_idx=0; first_block=0.
    - final block: pulse msg_done the next cycle, reset bitlen=0 and first_block=1, -> FILL.
    - len_pending: clear it, write bitlen into words 14,15 -> LEN.
    - otherwise -> FILL.
- LEN: one cycle -> SEND (final).
- computation_complete outside WAIT is ignored. in_valid outside FILL is not accepted, and the word is held by the source.
- enable_computation falls the cycle after computation_complete is seen.
- Latency: final input word accepted at cycle t -> begin_computation at t+1.
- Reset mid-operation: immediate abort to reset state. A block in flight in the SHA block is discarded, and msg_done does not pulse.

Test Plan:
- Empty message (in_last=1, in_nbytes=0) -> 1 block: word0=0x80000000, words1..15=0, length=0. first_block=1, begin pulse, msg_done one cycle after complete.
- "abc" (in_data=0x61626300, nbytes=3) -> word0=0x61626380, word15=0x00000018, others 0. Single block.
- 55 bytes (13 full words + 3-byte last) -> word13 ends 0x80, words14/15 = 0x00000000/0x000001B8. Single block.
- 56 bytes (14 full words, last nbytes=4) -> block0 word14=0x80000000, word15=0, first_block=1. Block1 words0..13=0, word15=0x000001C0, first_block=0. msg_done only after block1.
- 80-byte bitcoin header (20 words):
  - in_ready=0 from block0 SEND until its complete.
  - block1 word4=0x80000000, word15=0x00000280.
  - Delayed computation_complete (50 cycles) holds msg_block and enable_computation steady.
- Reset asserted in WAIT -> all outputs 0 immediately. Subsequent "abc" message produces the correct single block with first_block=1.
